// File: rtl/snd_mix_seq.sv
// Sequential BGM + NUM_SE effect mixer: one shared MAC, saturation, output slot.
// Optional peak meter enabled with `define SND_MIX_PEAK_EN.
module snd_mix_seq #(
  parameter int NUM_SE = 4,
  parameter int SMP_W  = 16,
  parameter int VOL_W  = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      FIFO_RD,
  output logic                      FIFO_VALID,
  output logic [2*SMP_W-1:0]        FIFO_DOUT,
  input  logic                      BGM_FIFO_VALID,
  input  logic [2*SMP_W-1:0]        BGM_FIFO_DOUT,
  output logic                      BGM_FIFO_RD,
  input  logic [NUM_SE-1:0]         SE_FIFO_VALID,
  input  logic [NUM_SE*2*SMP_W-1:0] SE_FIFO_DOUT,
  output logic [NUM_SE-1:0]         SE_FIFO_RD,
  input  logic [NUM_SE-1:0]         M_SE_SELECT,
  input  logic [VOL_W-1:0]          M_BGM_VOLUME,
  input  logic [VOL_W-1:0]          M_SE_VOLUME,
  output logic                      MIX_CLIP
`ifdef SND_MIX_PEAK_EN
  ,
  input  logic                      PEAK_CLR,
  output logic [SMP_W-1:0]          PEAK_L,
  output logic [SMP_W-1:0]          PEAK_R
`endif
);

  localparam int WW = 2 * SMP_W;
  localparam int PW = SMP_W + VOL_W + 1;
  localparam int AW = SMP_W + VOL_W + $clog2(NUM_SE + 2);
  localparam int KW = $clog2(NUM_SE + 1);
  localparam logic [KW-1:0] LASTK = KW'(NUM_SE);
  localparam logic signed [AW-1:0] MAXV =
    $signed({{(AW-SMP_W+1){1'b0}}, {(SMP_W-1){1'b1}}});
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [WW-1:0]           words_q [0:NUM_SE];
  logic [VOL_W-1:0]        bvol_q, svol_q;
  logic signed [AW-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [WW-1:0]           dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    clip_q, clip_d;

  logic                    go, slot_free, wr;
  logic [NUM_SE-1:0]       contrib;
  logic [VOL_W-1:0]        vol;
  logic signed [PW-1:0]    sl, sr, vx, pl, pr;
  logic signed [AW-1:0]    tl, tr;
  logic [SMP_W-1:0]        sat_l, sat_r;
  logic                    clip_l, clip_r;

  assign slot_free   = !valid_q || FIFO_RD;
  assign contrib     = SE_FIFO_VALID & M_SE_SELECT;
  // Pops are combinational so the source FIFO advances on the snapshot edge.
  assign go          = (state_q == IDLE) && BGM_FIFO_VALID && ARESETN;
  assign BGM_FIFO_RD = go;
  assign SE_FIFO_RD  = go ? contrib : '0;
  assign FIFO_VALID  = valid_q;
  assign FIFO_DOUT   = dout_q;
  assign MIX_CLIP    = clip_q;
  assign wr          = (state_q == SAT) && slot_free;

  assign vol = (k_q == '0) ? bvol_q : svol_q;
  assign sl  = PW'($signed(words_q[0][SMP_W-1:0]));
  assign sr  = PW'($signed(words_q[0][WW-1:SMP_W]));
  assign vx  = $signed(PW'({1'b0, vol}));
  assign pl  = sl * vx;
  assign pr  = sr * vx;
  assign tl  = AW'(pl >>> (VOL_W - 1));
  assign tr  = AW'(pr >>> (VOL_W - 1));

  always_comb begin
    sat_l  = acc_l_q[SMP_W-1:0];
    clip_l = 1'b0;
    if (acc_l_q > MAXV) begin
      sat_l  = MAXV[SMP_W-1:0];
      clip_l = 1'b1;
    end else if (acc_l_q < MINV) begin
      sat_l  = MINV[SMP_W-1:0];
      clip_l = 1'b1;
    end
    sat_r  = acc_r_q[SMP_W-1:0];
    clip_r = 1'b0;
    if (acc_r_q > MAXV) begin
      sat_r  = MAXV[SMP_W-1:0];
      clip_r = 1'b1;
    end else if (acc_r_q < MINV) begin
      sat_r  = MINV[SMP_W-1:0];
      clip_r = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    clip_d  = clip_q;
    if (FIFO_RD && valid_q) valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = ACC;
        k_d     = '0;
        acc_l_d = '0;
        acc_r_d = '0;
      end
      ACC: begin
        acc_l_d = acc_l_q + tl;
        acc_r_d = acc_r_q + tr;
        k_d     = k_q + 1'b1;
        if (k_q == LASTK) state_d = SAT;
      end
      SAT: if (slot_free) begin
        dout_d  = {sat_r, sat_l};
        valid_d = 1'b1;
        clip_d  = clip_q | clip_l | clip_r;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      bvol_q  <= '0;
      svol_q  <= '0;
      for (int i = 0; i <= NUM_SE; i++) words_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      if (go) begin
        bvol_q     <= M_BGM_VOLUME;
        svol_q     <= M_SE_VOLUME;
        words_q[0] <= BGM_FIFO_DOUT;
        for (int i = 0; i < NUM_SE; i++)
          words_q[i+1] <= contrib[i] ? SE_FIFO_DOUT[i*WW +: WW] : '0;
      end else if (state_q == ACC) begin
        // Shift so the MAC always reads slot 0.
        for (int i = 0; i < NUM_SE; i++) words_q[i] <= words_q[i+1];
        words_q[NUM_SE] <= '0;
      end
    end
  end

`ifdef SND_MIX_PEAK_EN
  logic [SMP_W-1:0] pk_l_q, pk_r_q, mag_l, mag_r;

  function automatic logic [SMP_W-1:0] mag(input logic [SMP_W-1:0] v);
    if (!v[SMP_W-1]) return v;
    if (v == {1'b1, {(SMP_W-1){1'b0}}}) return {1'b0, {(SMP_W-1){1'b1}}};
    return ~v + 1'b1;
  endfunction

  assign mag_l  = mag(sat_l);
  assign mag_r  = mag(sat_r);
  assign PEAK_L = pk_l_q;
  assign PEAK_R = pk_r_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pk_l_q <= '0;
      pk_r_q <= '0;
    end else if (PEAK_CLR) begin
      pk_l_q <= '0;
      pk_r_q <= '0;
    end else if (wr) begin
      if (mag_l > pk_l_q) pk_l_q <= mag_l;
      if (mag_r > pk_r_q) pk_r_q <= mag_r;
    end
  end
`endif

endmodule

// File: tb/tb_snd_mix_seq.sv
// Scoreboard bench for snd_mix_seq (NUM_SE=4, SMP_W=16, VOL_W=8).
// Source queue feeds the DUT; expected words are modelled at each BGM pop.
module tb_snd_mix_seq;
  localparam int N = 4;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic         FIFO_RD;
  logic         FIFO_VALID;
  logic [31:0]  FIFO_DOUT;
  logic         BGM_FIFO_VALID;
  logic [31:0]  BGM_FIFO_DOUT;
  logic         BGM_FIFO_RD;
  logic [3:0]   SE_FIFO_VALID;
  logic [127:0] SE_FIFO_DOUT;
  logic [3:0]   SE_FIFO_RD;
  logic [3:0]   M_SE_SELECT;
  logic [7:0]   M_BGM_VOLUME;
  logic [7:0]   M_SE_VOLUME;
  logic         MIX_CLIP;

  snd_mix_seq #(.NUM_SE(N), .SMP_W(16), .VOL_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .FIFO_RD(FIFO_RD), .FIFO_VALID(FIFO_VALID), .FIFO_DOUT(FIFO_DOUT),
    .BGM_FIFO_VALID(BGM_FIFO_VALID), .BGM_FIFO_DOUT(BGM_FIFO_DOUT),
    .BGM_FIFO_RD(BGM_FIFO_RD),
    .SE_FIFO_VALID(SE_FIFO_VALID), .SE_FIFO_DOUT(SE_FIFO_DOUT),
    .SE_FIFO_RD(SE_FIFO_RD), .M_SE_SELECT(M_SE_SELECT),
    .M_BGM_VOLUME(M_BGM_VOLUME), .M_SE_VOLUME(M_SE_VOLUME),
    .MIX_CLIP(MIX_CLIP)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0]  bgm;
    logic [127:0] se;
    logic [3:0]   sv;
    logic [3:0]   sel;
    logic [7:0]   bv;
    logic [7:0]   svol;
  } stim_t;

  stim_t       src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [3:0]  exp_se_q[$];
  logic [3:0]  got_se_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_bgm_rd = 0;

  function automatic stim_t mk(logic [31:0] bgm, logic [127:0] se,
                               logic [3:0] sv, logic [3:0] sel,
                               logic [7:0] bv, logic [7:0] svol);
    stim_t s;
    s.bgm = bgm; s.se = se; s.sv = sv; s.sel = sel;
    s.bv = bv; s.svol = svol;
    return s;
  endfunction

  function automatic logic [31:0] model(input stim_t s);
    logic [31:0] w;
    w = '0;
    for (int l = 0; l < 2; l++) begin
      int a;
      a = (int'($signed(s.bgm[l*16 +: 16])) * int'(s.bv)) >>> 7;
      for (int i = 0; i < 4; i++)
        if (s.sv[i] && s.sel[i])
          a += (int'($signed(s.se[i*32 + l*16 +: 16])) * int'(s.svol)) >>> 7;
      if (a > 32767) a = 32767;
      else if (a < -32768) a = -32768;
      w[l*16 +: 16] = a[15:0];
    end
    return w;
  endfunction

  // One clock: present source front, sample at negedge, return after posedge.
  task automatic step();
    if (src_q.size() > 0) begin
      BGM_FIFO_DOUT  = src_q[0].bgm;
      SE_FIFO_DOUT   = src_q[0].se;
      SE_FIFO_VALID  = src_q[0].sv;
      M_SE_SELECT    = src_q[0].sel;
      M_BGM_VOLUME   = src_q[0].bv;
      M_SE_VOLUME    = src_q[0].svol;
      BGM_FIFO_VALID = 1'b1;
    end else begin
      BGM_FIFO_VALID = 1'b0;
      SE_FIFO_VALID  = '0;
    end
    @(negedge ACLK);
    if (FIFO_VALID && FIFO_RD) got_q.push_back(FIFO_DOUT);
    if (BGM_FIFO_RD && src_q.size() > 0) begin
      exp_q.push_back(model(src_q[0]));
      exp_se_q.push_back(src_q[0].sv & src_q[0].sel);
      got_se_q.push_back(SE_FIFO_RD);
      void'(src_q.pop_front());
      n_bgm_rd++;
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic drain(output bit ok);
    FIFO_RD = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (src_q.size() == 0 && got_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    FIFO_RD = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; FIFO_RD = 1'b0; BGM_FIFO_VALID = 1'b1;
    BGM_FIFO_DOUT = '0; SE_FIFO_VALID = 4'hF; SE_FIFO_DOUT = '0;
    M_SE_SELECT = 4'hF; M_BGM_VOLUME = 8'h80; M_SE_VOLUME = 8'h80;
    #12;
    checks++; if (FIFO_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", FIFO_VALID); end
    checks++; if (FIFO_DOUT !== 32'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0", FIFO_DOUT); end
    checks++; if (BGM_FIFO_RD !== 1'b0) begin failures++; $display("FAIL rst_bgm_rd got=%b exp=0", BGM_FIFO_RD); end
    checks++; if (SE_FIFO_RD !== 4'h0) begin failures++; $display("FAIL rst_se_rd got=%h exp=0", SE_FIFO_RD); end
    checks++; if (MIX_CLIP !== 1'b0) begin failures++; $display("FAIL rst_clip got=%b exp=0", MIX_CLIP); end
    BGM_FIFO_VALID = 1'b0; SE_FIFO_VALID = '0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_bgm_only();
    int rd0;
    logic [31:0] e, g;
    logic [3:0] es, gs;
    rd0 = n_bgm_rd;
    FIFO_RD = 1'b0;
    src_q.push_back(mk(32'h1000_0800, '0, 4'h0, 4'hF, 8'h80, 8'h80));
    // Step c ends just after the c-th edge, counting the snapshot edge as 1.
    for (int c = 1; c <= N + 3; c++) begin
      step();
      if (c == N + 2) begin
        checks++; if (FIFO_VALID !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", FIFO_VALID); end
      end
      if (c == N + 3) begin
        checks++; if (FIFO_VALID !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", FIFO_VALID); end
      end
    end
    checks++; if (n_bgm_rd - rd0 !== 1) begin failures++; $display("FAIL bgm_pops got=%0d exp=1", n_bgm_rd - rd0); end
    checks++; if (FIFO_DOUT !== 32'h1000_0800) begin failures++; $display("FAIL bgm_word got=%h exp=10000800", FIFO_DOUT); end
    FIFO_RD = 1'b1;
    step();
    FIFO_RD = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL bgm_sb got=%h exp=%h", g, e); end
    end
    while (exp_se_q.size() > 0) begin
      es = exp_se_q.pop_front(); gs = got_se_q.pop_front();
      checks++; if (gs !== es) begin failures++; $display("FAIL bgm_se_rd got=%b exp=%b", gs, es); end
    end
  endtask

  task automatic test_select();
    bit ok;
    logic [31:0] e, g;
    logic [3:0] gs;
    src_q.push_back(mk(32'h1000_0800, {4{32'h0100_0100}}, 4'hF, 4'b0101,
                       8'h80, 8'h80));
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sel_timeout got=0 exp=1"); end
    gs = got_se_q.pop_front(); void'(exp_se_q.pop_front());
    checks++; if (gs !== 4'b0101) begin failures++; $display("FAIL sel_se_rd got=%b exp=0101", gs); end
    e = exp_q.pop_front();
    g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
    checks++; if (g !== e) begin failures++; $display("FAIL sel_sb got=%h exp=%h", g, e); end
    checks++; if (g !== 32'h1200_0A00) begin failures++; $display("FAIL sel_word got=%h exp=12000a00", g); end
  endtask

  task automatic test_gain();
    bit ok;
    logic [31:0] e, g;
    logic [31:0] k [3];
    k[0] = 32'h2000_2000; k[1] = 32'h7F80_7F80; k[2] = 32'h0;
    src_q.push_back(mk(32'h4000_4000, '0, 4'h0, 4'h0, 8'h40, 8'h80));
    src_q.push_back(mk(32'h4000_4000, '0, 4'h0, 4'h0, 8'hFF, 8'h80));
    src_q.push_back(mk(32'h4000_4000, '0, 4'h0, 4'h0, 8'h00, 8'h80));
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL gain_timeout got=0 exp=1"); end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL gain_sb%0d got=%h exp=%h", i, g, e); end
      checks++; if (g !== k[i]) begin failures++; $display("FAIL gain_const%0d got=%h exp=%h", i, g, k[i]); end
    end
    exp_se_q.delete(); got_se_q.delete();
  endtask

  task automatic test_saturation();
    bit ok;
    logic [31:0] e, g;
    logic [31:0] k [2];
    k[0] = 32'h7FFF_7FFF; k[1] = 32'h8000_8000;
    checks++; if (MIX_CLIP !== 1'b0) begin failures++; $display("FAIL clip_pre got=%b exp=0", MIX_CLIP); end
    src_q.push_back(mk(32'h7000_7000, {96'h0, 32'h7000_7000}, 4'h1, 4'h1,
                       8'h80, 8'h80));
    src_q.push_back(mk(32'h9000_9000, {96'h0, 32'h9000_9000}, 4'h1, 4'h1,
                       8'h80, 8'h80));
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sat_timeout got=0 exp=1"); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL sat_sb%0d got=%h exp=%h", i, g, e); end
      checks++; if (g !== k[i]) begin failures++; $display("FAIL sat_const%0d got=%h exp=%h", i, g, k[i]); end
    end
    checks++; if (MIX_CLIP !== 1'b1) begin failures++; $display("FAIL clip_set got=%b exp=1", MIX_CLIP); end
    exp_se_q.delete(); got_se_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rd0;
    logic [31:0] e, g;
    rd0 = n_bgm_rd;
    FIFO_RD = 1'b0;
    src_q.push_back(mk(32'h0123_0456, {32'h0010_FF00, 32'h0200_0300,
                       32'hFFF0_0040, 32'h0100_FE00}, 4'hF, 4'hF, 8'h80, 8'h40));
    src_q.push_back(mk(32'hF000_0F00, {32'h0, 32'h0400_0400, 32'h0, 32'h1000_E000},
                       4'b0101, 4'b1111, 8'hC0, 8'h80));
    src_q.push_back(mk(32'h2222_DDDE, {4{32'h0111_0222}}, 4'hF, 4'b1010,
                       8'h60, 8'hA0));
    for (int c = 0; c < 3 * (N + 3); c++) step();
    checks++; if (n_bgm_rd - rd0 !== 2) begin failures++; $display("FAIL bp_pops got=%0d exp=2", n_bgm_rd - rd0); end
    checks++; if (FIFO_VALID !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", FIFO_VALID); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=0 exp=1"); end
    for (int i = 0; i < 3; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL bp_sb%0d got=%h exp=%h", i, g, e); end
    end
    while (exp_se_q.size() > 0) begin
      e = 32'(exp_se_q.pop_front()); g = 32'(got_se_q.pop_front());
      checks++; if (g !== e) begin failures++; $display("FAIL bp_se_rd got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] e, g;
    checks++; if (MIX_CLIP !== 1'b1) begin failures++; $display("FAIL mid_clip_pre got=%b exp=1", MIX_CLIP); end
    FIFO_RD = 1'b0;
    src_q.push_back(mk(32'h7FFF_7FFF, {4{32'h7FFF_7FFF}}, 4'hF, 4'hF, 8'hFF, 8'hFF));
    step();
    step();
    BGM_FIFO_VALID = 1'b1; SE_FIFO_VALID = 4'hF;
    ARESETN = 1'b0;
    #1;
    checks++; if (FIFO_VALID !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", FIFO_VALID); end
    checks++; if (BGM_FIFO_RD !== 1'b0) begin failures++; $display("FAIL mid_bgm_rd got=%b exp=0", BGM_FIFO_RD); end
    checks++; if (SE_FIFO_RD !== 4'h0) begin failures++; $display("FAIL mid_se_rd got=%h exp=0", SE_FIFO_RD); end
    checks++; if (MIX_CLIP !== 1'b0) begin failures++; $display("FAIL mid_clip got=%b exp=0", MIX_CLIP); end
    exp_q.delete(); got_q.delete(); exp_se_q.delete(); got_se_q.delete();
    BGM_FIFO_VALID = 1'b0; SE_FIFO_VALID = '0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    src_q.push_back(mk(32'hFF00_0100, {96'h0, 32'h0080_FF80}, 4'h1, 4'h1, 8'h80, 8'h80));
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=0 exp=1"); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
    checks++; if (g !== e) begin failures++; $display("FAIL mid_sb got=%h exp=%h", g, e); end
    checks++; if (g !== 32'hFF80_0080) begin failures++; $display("FAIL mid_word got=%h exp=ff800080", g); end
  endtask

  initial begin
    test_reset();
    test_bgm_only();
    test_select();
    test_gain();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
